quiz_score: RTL
===============

# quiz_score

Scoring engine for the quiz game: arbitrates player buzz-ins, applies host correct/wrong verdicts and answer timeouts to per-player scores, and declares the first player to reach the target score as the winner. It is active in the game view (view 1) and produces the `player_count`-indexed scores and `winner` consumed by the win view (view 2). It freezes its outputs outside view 1 so the win view reads stable values.

## Interface
- `CLK_PER_MS`, 100_000: clock cycles per millisecond tick.
- `ANSWER_MS`, 5000: answer window in ms before an automatic wrong verdict.
- `TARGET`, 10: winning score, range 1..99.
- `CORRECT_PTS`, 2: points added on a correct verdict.
- `WRONG_PTS`, 1: points subtracted on a wrong verdict or timeout.

Ports:
- `clk` in 1: system clock, the only clock.
- `rst` in 1: synchronous, active-high reset.
- `view` in 3: current view. 0 = setup, 1 = game, 2 = win.
- `player_count` in 3: number of active players, 1..4.
- `btn` in 4: debounced player buttons, level, active-high. Bit k is player k+1.
- `host_correct` in 1: single-cycle verdict pulse.
- `host_wrong` in 1: single-cycle verdict pulse.
- `player1_score` .. `player4_score` out 7 each: scores, 0..99.
- `responder` out 3: player currently holding the answer, 0 = none.
- `winner` out 3: winning player 1..4, 0 = none.
- `game_over` out 1: level, high once a winner is declared.

## Operation
- **States:** WAIT, LOCKED, OVER.
  - Reset and view 0 force WAIT, all scores 0, `responder` 0, `winner` 0, `game_over` 0, ms counter 0, timeout counter 0, button history 0.
- **View 2..7:** every register holds its value, including state, scores and timers. The button history register still tracks `btn`.
- **Press detection:** a rising edge on `btn[k]` is `btn[k]` high with history bit k low. The history register updates every cycle in view 1.
  - Bits with k+1 > `player_count` are masked.
- **WAIT, view 1:** on any unmasked rising edge, the lowest-numbered pressing player wins the tie.
  - `responder` takes that player.
  - State goes to LOCKED.
  - Timeout counter clears.
  - Verdict pulses in WAIT are ignored.
- **LOCKED:**
  - All presses are ignored. The history still updates, so a button held through LOCKED does not fire later.
  - The ms tick is 1 cycle every `CLK_PER_MS` cycles. The timeout counter increments on each tick.
- **Verdict priority in LOCKED:**
  - `host_correct` and `host_wrong` in the same cycle: both ignored, no change.
  - Otherwise, a verdict beats a timeout in the same cycle.
  - A timeout fires when the counter reaches `ANSWER_MS`. It is treated as wrong.
- **Correct verdict:** responder score becomes min(score + `CORRECT_PTS`, 99).
- **Wrong verdict or timeout:** responder score becomes max(score − `WRONG_PTS`, 0).
- **After a verdict:** `responder` goes to 0.
  - If the new score ≥ `TARGET`: state goes to OVER, `winner` = responder, `game_over` = 1.
  - Otherwise state goes to WAIT.
- **OVER:** absorbing until `rst` or view 0. Presses and verdicts are ignored.
- **Arithmetic:** compute in 8 bits, then saturate to 0..99. Scores of inactive players stay 0.

## Timing
- Press to `responder` valid: 1 cycle. A rising edge sampled at edge n makes `responder` visible after edge n.
- Verdict pulse to score, `responder`, `winner` and `game_over` update: 1 cycle, all on the same edge.
- Timeout fires `ANSWER_MS`×`CLK_PER_MS` cycles (±`CLK_PER_MS`) after LOCKED entry. The ms divider free-runs in view 1.
- A new press is accepted on the cycle after return to WAIT.
- A view change takes effect on the next edge.
- `rst` mid-LOCKED clears everything on that edge. No pending verdict survives.

## Test plan
Bench parameters: `CLK_PER_MS`=10, `ANSWER_MS`=3, `TARGET`=4, `player_count`=3, view 1.

- **Simultaneous press:** `btn`=4'b0110 in one cycle -> `responder`=2 next cycle. Then `host_correct` -> `player2_score`=2, `responder`=0.
- **Masked player:** `btn[3]` pulse -> no change.
- **Held button:** player 1 holds its button through a LOCKED period for player 3. The verdict is applied, then the button keeps being held -> no re-lock until release and re-press.
- **Wrong at zero:** player 1 at 0, buzz-in, `host_wrong` -> score stays 0.
- **Timeout:** no verdict for 30 cycles -> wrong applied, state returns to WAIT.
- **Conflicting verdicts:** both pulses high in the same cycle -> no change, still LOCKED. A later `host_correct` is then applied.
- **Win and freeze:** player 2 reaches 4 -> `winner`=2, `game_over`=1. Further presses are ignored. Switching to view 2 keeps all scores. View 0 -> all outputs 0.
- **Reset mid-answer:** `rst` pulse while LOCKED -> next cycle all outputs 0, state WAIT.

Source files
------------

// File: rtl/quiz_score_if.sv
// ============================================================================
//  Module      : quiz_score_if
//  Description : Game-view bus for the quiz scoring engine. It carries the
//                view, player and host controls in, and the scores out.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface quiz_score_if;
    logic [2:0] view;
    logic [2:0] player_count;
    logic [3:0] btn;
    logic       host_correct;
    logic       host_wrong;
    logic [6:0] player1_score;
    logic [6:0] player2_score;
    logic [6:0] player3_score;
    logic [6:0] player4_score;
    logic [2:0] responder;
    logic [2:0] winner;
    logic       game_over;

    modport master (
        output view, player_count, btn, host_correct, host_wrong,
        input  player1_score, player2_score, player3_score, player4_score,
        input  responder, winner, game_over
    );

    modport slave (
        input  view, player_count, btn, host_correct, host_wrong,
        output player1_score, player2_score, player3_score, player4_score,
        output responder, winner, game_over
    );
endinterface

`default_nettype wire

// File: rtl/quiz_score.sv
// ============================================================================
//  Module      : quiz_score
//  Description : Quiz scoring engine. Arbitrates buzz-ins, applies verdicts
//                and timeouts, and declares the winner.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module quiz_score #(
    parameter int CLK_PER_MS  = 100_000,
    parameter int ANSWER_MS   = 5000,
    parameter int TARGET      = 10,
    parameter int CORRECT_PTS = 2,
    parameter int WRONG_PTS   = 1
) (
    input  wire logic     clk,
    input  wire logic     rst,
    quiz_score_if.slave   bus
);

    localparam int MS_W = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam int TO_W = $clog2(ANSWER_MS + 1);
    localparam logic [MS_W-1:0] c_MS_LAST = MS_W'(CLK_PER_MS - 1);
    localparam logic [TO_W-1:0] c_TO_LAST = TO_W'(ANSWER_MS);

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_LOCKED = 2'd1,
        ST_OVER   = 2'd2
    } state_t;

    state_t          r_state, w_nxt_state;
    logic [6:0]      r_score [4];
    logic [6:0]      w_nxt_score [4];
    logic [2:0]      r_resp, w_nxt_resp;
    logic [2:0]      r_winner, w_nxt_winner;
    logic            r_over, w_nxt_over;
    logic [MS_W-1:0] r_ms_cnt, w_nxt_ms;
    logic [TO_W-1:0] r_to_cnt, w_nxt_to;
    logic [3:0]      r_hist, w_nxt_hist;

    logic [3:0]      w_mask, w_rise;
    logic [2:0]      w_pick;
    logic [1:0]      w_idx;
    logic            w_tick, w_timeout, w_do_correct, w_do_wrong;
    logic [7:0]      w_cur, w_up, w_dn;
    logic [6:0]      w_new_score;

    assign w_mask = {bus.player_count > 3'd3, bus.player_count > 3'd2,
                     bus.player_count > 3'd1, bus.player_count > 3'd0};
    assign w_rise = bus.btn & ~r_hist & w_mask;

    // Lowest-numbered player wins a simultaneous buzz.
    always_comb begin
        w_pick = 3'd0;
        if      (w_rise[0]) w_pick = 3'd1;
        else if (w_rise[1]) w_pick = 3'd2;
        else if (w_rise[2]) w_pick = 3'd3;
        else if (w_rise[3]) w_pick = 3'd4;
    end

    assign w_tick    = (r_ms_cnt == c_MS_LAST);
    assign w_timeout = (r_to_cnt == c_TO_LAST);

    // Conflicting pulses cancel each other and also hold off a timeout.
    assign w_do_correct = bus.host_correct & ~bus.host_wrong;
    assign w_do_wrong   = (bus.host_wrong & ~bus.host_correct) |
                          (w_timeout & ~bus.host_correct & ~bus.host_wrong);

    assign w_idx = 2'(r_resp - 3'd1);
    assign w_cur = {1'b0, r_score[w_idx]};
    assign w_up  = w_cur + 8'(CORRECT_PTS);
    assign w_dn  = (w_cur < 8'(WRONG_PTS)) ? 8'd0 : (w_cur - 8'(WRONG_PTS));

    always_comb begin
        w_new_score = 7'd0;
        if (w_do_correct)
            w_new_score = (w_up > 8'd99) ? 7'd99 : w_up[6:0];
        else
            w_new_score = (w_dn > 8'd99) ? 7'd99 : w_dn[6:0];
    end

    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_score  = r_score;
        w_nxt_resp   = r_resp;
        w_nxt_winner = r_winner;
        w_nxt_over   = r_over;
        w_nxt_ms     = r_ms_cnt;
        w_nxt_to     = r_to_cnt;
        w_nxt_hist   = bus.btn;

        if (bus.view == 3'd1) begin
            w_nxt_ms = w_tick ? '0 : r_ms_cnt + 1'b1;
            case (r_state)
                ST_WAIT: begin
                    if (w_pick != 3'd0) begin
                        w_nxt_resp  = w_pick;
                        w_nxt_state = ST_LOCKED;
                        w_nxt_to    = '0;
                    end
                end
                ST_LOCKED: begin
                    if (w_tick && !w_timeout)
                        w_nxt_to = r_to_cnt + 1'b1;
                    if (w_do_correct || w_do_wrong) begin
                        w_nxt_score[w_idx] = w_new_score;
                        w_nxt_resp         = 3'd0;
                        if ({1'b0, w_new_score} >= 8'(TARGET)) begin
                            w_nxt_state  = ST_OVER;
                            w_nxt_winner = r_resp;
                            w_nxt_over   = 1'b1;
                        end else begin
                            w_nxt_state = ST_WAIT;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Setup view acts as a game reset; win view freezes everything but history.
    always_ff @(posedge clk) begin
        if (rst || bus.view == 3'd0) begin
            r_state  <= ST_WAIT;
            for (int i = 0; i < 4; i++) r_score[i] <= 7'd0;
            r_resp   <= 3'd0;
            r_winner <= 3'd0;
            r_over   <= 1'b0;
            r_ms_cnt <= '0;
            r_to_cnt <= '0;
            r_hist   <= 4'd0;
        end else begin
            r_state  <= w_nxt_state;
            r_score  <= w_nxt_score;
            r_resp   <= w_nxt_resp;
            r_winner <= w_nxt_winner;
            r_over   <= w_nxt_over;
            r_ms_cnt <= w_nxt_ms;
            r_to_cnt <= w_nxt_to;
            r_hist   <= w_nxt_hist;
        end
    end

    assign bus.player1_score = r_score[0];
    assign bus.player2_score = r_score[1];
    assign bus.player3_score = r_score[2];
    assign bus.player4_score = r_score[3];
    assign bus.responder     = r_resp;
    assign bus.winner        = r_winner;
    assign bus.game_over     = r_over;

endmodule

`default_nettype wire
